// File: rtl/muxnto1_rr.sv
// Registered N-to-1 multiplexer with per-channel valid/ready and fixed or round-robin selection.
// Optional handshake counter on XferCount when MUXNTO1_STATS_EN is defined.
module muxnto1_rr #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N*WIDTH-1:0]   W,
  input  logic [N-1:0]         Valid,
  output logic [N-1:0]         Ready,
  input  logic                 Mode,
  input  logic [SELW-1:0]      S,
  output logic [WIDTH-1:0]     f,
  output logic                 fValid,
  input  logic                 fReady,
`ifdef MUXNTO1_STATS_EN
  output logic [15:0]          XferCount,
`endif
  output logic [SELW-1:0]      Grant
);

  logic [WIDTH-1:0] f_q, f_d;
  logic             fvalid_q, fvalid_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             load;
  logic             acc;
  logic             request;
  logic [SELW-1:0]  cand;
  logic             fixed_req;
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic [N-1:0]     cand_oh;
  logic [WIDTH-1:0] mux_data;

  // Enabled binary-to-one-hot decoder.
  function automatic logic [N-1:0] dec_en(input logic [SELW-1:0] idx, input logic en);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (SELW'(i) == idx)) begin
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  // Fixed mode: a select outside 0..N-1 never matches a channel, so never requests.
  always_comb begin
    fixed_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((SELW'(i) == S) && Valid[i]) begin
        fixed_req = 1'b1;
      end
    end
  end

  // Round-robin: channels above last_q first, then wrap to channel 0 up to last_q.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!rr_found && Valid[i] && (SELW'(i) > last_q)) begin
        rr_found = 1'b1;
        rr_idx   = SELW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rr_found && Valid[i] && (SELW'(i) <= last_q)) begin
        rr_found = 1'b1;
        rr_idx   = SELW'(i);
      end
    end
  end

  always_comb begin
    if (Mode) begin
      cand    = rr_idx;
      request = rr_found;
    end else begin
      cand    = S;
      request = fixed_req;
    end
  end

  assign load = ~fvalid_q | fReady;
  assign acc  = load & request & ~Reset;

  assign cand_oh = dec_en(cand, request);
  assign Ready   = dec_en(cand, acc);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      mux_data = mux_data | (W[i*WIDTH +: WIDTH] & {WIDTH{cand_oh[i]}});
    end
  end

  always_comb begin
    f_d      = f_q;
    fvalid_d = fvalid_q;
    grant_d  = grant_q;
    last_d   = last_q;
    if (load) begin
      if (acc) begin
        f_d      = mux_data;
        grant_d  = cand;
        fvalid_d = 1'b1;
        if (Mode) begin
          last_d = cand;
        end
      end else begin
        fvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      f_q      <= '0;
      fvalid_q <= 1'b0;
      grant_q  <= '0;
      last_q   <= SELW'(N - 1);
    end else begin
      f_q      <= f_d;
      fvalid_q <= fvalid_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  assign f      = f_q;
  assign fValid = fvalid_q;
  assign Grant  = grant_q;

`ifdef MUXNTO1_STATS_EN
  logic [15:0] xfer_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      xfer_q <= '0;
    end else if (fvalid_q && fReady) begin
      xfer_q <= xfer_q + 16'd1;
    end
  end

  assign XferCount = xfer_q;
`endif

endmodule
